// File: rtl/adcfilt_pkg.sv
// Shared types and helpers for the ADC input filter.
package adcfilt_pkg;

    typedef enum logic {
        EMPTY = 1'b0,
        RUN   = 1'b1
    } state_t;

    function automatic int unsigned sum_width(input int unsigned adc_bw,
                                              input int unsigned depth_log2);
        return adc_bw + depth_log2;
    endfunction

    // N/2: added before the shift so the average rounds half up
    function automatic int unsigned round_const(input int unsigned depth_log2);
        return (depth_log2 == 0) ? 0 : (32'd1 << (depth_log2 - 1));
    endfunction

endpackage

// File: rtl/adc_input_filter_sync.sv
// Parameterised multi-stage bus synchroniser, async active-high reset to 0.
module adc_sync #(
    parameter int unsigned WIDTH  = 4,
    parameter int unsigned STAGES = 2
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [WIDTH-1:0] i_d,
    output logic [WIDTH-1:0] o_q
);

    logic [WIDTH-1:0] r_sync [STAGES];

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int i = 0; i < int'(STAGES); i++) begin
                r_sync[i] <= '0;
            end
        end else begin
            r_sync[0] <= i_d;
            for (int i = 1; i < int'(STAGES); i++) begin
                r_sync[i] <= r_sync[i-1];
            end
        end
    end

    assign o_q = r_sync[STAGES-1];

endmodule

// File: rtl/adc_input_filter.sv
// ADC front end: synchronise, decimate, rounded moving average, valid/ready output.
// Optional spike rejection is built when ADCFILT_SPIKE_REJECT_EN is defined.
module adc_input_filter
    import adcfilt_pkg::*;
#(
    parameter int unsigned ADC_BITWIDTH   = 4,
    parameter int unsigned AVG_DEPTH_LOG2 = 2,
    parameter int unsigned SAMPLE_DIV     = 1000,
    parameter int unsigned SYNC_STAGES    = 2,
    parameter int unsigned SPIKE_THRESH   = 4
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic                    clk_en_i,
    input  logic [ADC_BITWIDTH-1:0] ADC_value_i,
    input  logic                    ready_i,
    output logic [ADC_BITWIDTH-1:0] ADC_value_o,
    output logic                    valid_o,
    output logic                    overrun_o
);

    localparam int unsigned W        = ADC_BITWIDTH;
    localparam int unsigned D        = AVG_DEPTH_LOG2;
    localparam int unsigned N        = 32'd1 << D;
    localparam int unsigned SUM_W    = sum_width(ADC_BITWIDTH, AVG_DEPTH_LOG2);
    localparam int unsigned GW       = SUM_W + 1;
    localparam int unsigned DIV_W    = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;
    localparam int unsigned MAX_CODE = (32'd1 << W) - 1;
    localparam int unsigned RND      = round_const(AVG_DEPTH_LOG2);

    // Elaboration-time parameter legality checks
    if (D < 1 || D > 4) begin : g_bad_depth
        $error("AVG_DEPTH_LOG2 must be in 1..4");
    end
    if (SAMPLE_DIV < 2) begin : g_bad_div
        $error("SAMPLE_DIV must be >= 2");
    end
    if (SYNC_STAGES < 2) begin : g_bad_sync
        $error("SYNC_STAGES must be >= 2");
    end
    if (SPIKE_THRESH > MAX_CODE) begin : g_bad_thresh
        $error("SPIKE_THRESH exceeds the ADC code range");
    end

    logic [W-1:0]       w_sample;
    logic [DIV_W-1:0]   r_div;
    logic               w_tick;
    logic               w_accept;
    state_t             r_state;
    state_t             w_state_nxt;
    logic               w_fill;
    logic               w_push;
    logic [W-1:0]       r_buf [N];
    logic [D-1:0]       r_wp;
    logic [SUM_W-1:0]   r_sum;
    logic [GW-1:0]      w_sum_ext;
    logic [SUM_W-1:0]   w_sum_nxt;
    logic [GW-1:0]      w_rounded;
    logic [W-1:0]       w_result;

    adc_sync #(
        .WIDTH  (W),
        .STAGES (SYNC_STAGES)
    ) u_sync (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .i_d   (ADC_value_i),
        .o_q   (w_sample)
    );

    // Sample-rate divider, advances only on enabled cycles
    assign w_tick = clk_en_i && (r_div == DIV_W'(SAMPLE_DIV - 1));

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_div <= '0;
        end else if (clk_en_i) begin
            r_div <= w_tick ? '0 : r_div + DIV_W'(1);
        end
    end

`ifdef ADCFILT_SPIKE_REJECT_EN
    logic         r_reject;
    logic [W-1:0] w_diff;
    logic         w_spike;

    assign w_diff  = (w_sample >= ADC_value_o) ? (w_sample - ADC_value_o)
                                               : (ADC_value_o - w_sample);
    assign w_spike = 32'(w_diff) > SPIKE_THRESH;
    // A lone outlier is dropped; a second one in a row is taken as real
    assign w_accept = w_tick && ((r_state == EMPTY) || !w_spike || r_reject);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_reject <= 1'b0;
        end else if (w_tick) begin
            r_reject <= (r_state == RUN) && w_spike && !r_reject;
        end
    end
`else
    assign w_accept = w_tick;
`endif

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state <= EMPTY;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_fill      = 1'b0;
        w_push      = 1'b0;
        case (r_state)
            EMPTY: begin
                if (w_accept) begin
                    w_fill      = 1'b1;
                    w_state_nxt = RUN;
                end
            end
            RUN: begin
                if (w_accept) begin
                    w_push = 1'b1;
                end
            end
            default: w_state_nxt = EMPTY;
        endcase
    end

    // Running sum; the extra bit absorbs the add before the subtract
    always_comb begin
        w_sum_ext = GW'(r_sum) + GW'(w_sample) - GW'(r_buf[r_wp]);
        w_sum_nxt = r_sum;
        if (w_fill) begin
            w_sum_nxt = SUM_W'(w_sample) << D;
        end else if (w_push) begin
            w_sum_nxt = w_sum_ext[SUM_W] ? '1 : w_sum_ext[SUM_W-1:0];
        end
    end

    always_comb begin
        w_rounded = (GW'(w_sum_nxt) + GW'(RND)) >> D;
        w_result  = (w_rounded > GW'(MAX_CODE)) ? W'(MAX_CODE) : w_rounded[W-1:0];
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int i = 0; i < int'(N); i++) begin
                r_buf[i] <= '0;
            end
            r_wp  <= '0;
            r_sum <= '0;
        end else begin
            r_sum <= w_sum_nxt;
            if (w_fill) begin
                for (int i = 0; i < int'(N); i++) begin
                    r_buf[i] <= w_sample;
                end
            end else if (w_push) begin
                r_buf[r_wp] <= w_sample;
                r_wp        <= r_wp + D'(1);
            end
        end
    end

    // Output handshake; a new result may replace an unaccepted one
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            ADC_value_o <= '0;
            valid_o     <= 1'b0;
            overrun_o   <= 1'b0;
        end else if (clk_en_i) begin
            if (w_accept) begin
                ADC_value_o <= w_result;
                valid_o     <= 1'b1;
                if (valid_o && !ready_i) begin
                    overrun_o <= 1'b1;
                end
            end else if (valid_o && ready_i) begin
                valid_o <= 1'b0;
            end
        end
    end

endmodule
